// File: rtl/sorted_stream_merger.sv
// sorted_stream_merger
//
// Merges two packets, each already sorted, into one sorted output packet.
// A and B each arrive on their own valid/ready stream, and the merged words
// leave on a registered valid/ready stream. The merge order is chosen per
// packet by 'dir' (0 = ascending, 1 = descending). It is captured while the
// block is idle and held for the rest of the packet.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous, active-low reset
//   dir                      merge order, sampled only while idle
//   a_data/a_valid/a_last    stream A input word, its qualifier and its
//                            end-of-packet marker
//   a_ready                  stream A word accepted when a_valid && a_ready
//   b_data/b_valid/b_last    stream B input word, its qualifier and its
//                            end-of-packet marker
//   b_ready                  stream B word accepted when b_valid && b_ready
//   m_data/m_valid/m_last    merged output word (registered), its qualifier
//                            and its end-of-packet marker
//   m_ready                  downstream accepts when m_valid && m_ready
//   busy                     high whenever a packet is in progress
//   err                      sticky flag: an input stream arrived out of order
module sorted_stream_merger #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    DRAIN_A,
    DRAIN_B
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] prev_a_q, prev_b_q;
  logic             have_a_q, have_b_q;

  logic             load_en;
  logic             both_valid;
  logic             pick_a;
  logic             a_acc, b_acc;
  logic             a_bad, b_bad;

  // The output register can take a new word when it is empty, or when its
  // current word leaves on this same edge.
  assign load_en    = !m_valid_q || m_ready;
  assign both_valid = a_valid && b_valid;

  // The comparison includes equality, so on a tie A wins in both directions.
  assign pick_a = dir_q ? (a_data >= b_data) : (a_data <= b_data);

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  // A word is out of order when it moves against the packet's direction,
  // compared with the previous word accepted from the same side. The first
  // word of each side is not checked, because have_x_q is still clear.
  assign a_bad = have_a_q && (dir_q ? (a_data > prev_a_q) : (a_data < prev_a_q));
  assign b_bad = have_b_q && (dir_q ? (b_data > prev_b_q) : (b_data < prev_b_q));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. When a side's last word is consumed during MERGE, the
  // block moves to draining the other side. Leaving a drain state ends the
  // packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (both_valid) begin
          state_d = MERGE;
        end
      end
      MERGE: begin
        if (a_acc && a_last) begin
          state_d = DRAIN_B;
        end else if (b_acc && b_last) begin
          state_d = DRAIN_A;
        end
      end
      DRAIN_A: begin
        if (a_acc && a_last) begin
          state_d = IDLE;
        end
      end
      DRAIN_B: begin
        if (b_acc && b_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic for the handshakes. During MERGE only the side that wins
  // the comparison is offered a ready, and only when both words are present
  // to compare. Both readies are held low while reset is asserted.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      MERGE: begin
        if (both_valid && load_en) begin
          a_ready = pick_a;
          b_ready = !pick_a;
        end
      end
      DRAIN_A: a_ready = load_en;
      DRAIN_B: b_ready = load_en;
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
    if (!rst) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  // Next value of the output register. The merged packet's last flag comes
  // only from the side being drained. A last flag seen during MERGE only
  // starts the drain.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (load_en) begin
      m_valid_d = a_acc || b_acc;
      m_last_d  = ((state_q == DRAIN_A) && a_acc && a_last) ||
                  ((state_q == DRAIN_B) && b_acc && b_last);
      if (a_acc) begin
        m_data_d = a_data;
      end else if (b_acc) begin
        m_data_d = b_data;
      end
    end
  end

  // The error flag is sticky. Only reset clears it.
  always_comb begin
    err_d = err_q;
    if ((a_acc && a_bad) || (b_acc && b_bad)) begin
      err_d = 1'b1;
    end
  end

  // Output register, direction capture and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
      if (state_q == IDLE) begin
        dir_q <= dir;
      end
    end
  end

  // Records the previous word accepted from each side. These records are
  // cleared while idle, so every packet starts with no history on either
  // side.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_a_q <= '0;
      prev_b_q <= '0;
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
    end else if (state_q == IDLE) begin
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
    end else begin
      if (a_acc) begin
        prev_a_q <= a_data;
        have_a_q <= 1'b1;
      end
      if (b_acc) begin
        prev_b_q <= b_data;
        have_b_q <= 1'b1;
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign err     = err_q;

endmodule
